// File: rtl/axis_rx_sink_if.sv
// AXI-Stream slave bundle plus the FIFO read port of the stream sink.
// The slave modport is the sink's view; master is the source/consumer side.
interface axis_rx_sink_if #(
   parameter int DATA_W = 32,
   parameter int ID_W   = 4,
   parameter int DEST_W = 4,
   parameter int USER_W = 1
);
   localparam int KEEP_W = DATA_W / 8;

   logic              TVALID;
   logic              TREADY;
   logic [DATA_W-1:0] TDATA;
   logic [KEEP_W-1:0] TSTRB;
   logic [KEEP_W-1:0] TKEEP;
   logic              TLAST;
   logic [ID_W-1:0]   TID;
   logic [DEST_W-1:0] TDEST;
   logic [USER_W-1:0] TUSER;

   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic [KEEP_W-1:0] rd_strb;
   logic [KEEP_W-1:0] rd_keep;
   logic              rd_last;
   logic [ID_W-1:0]   rd_id;
   logic [DEST_W-1:0] rd_dest;
   logic [USER_W-1:0] rd_user;

   modport slave (
      input  TVALID, TDATA, TSTRB, TKEEP, TLAST,
      input  TID, TDEST, TUSER, rd_ready,
      output TREADY, rd_valid, rd_data, rd_strb,
      output rd_keep, rd_last, rd_id, rd_dest, rd_user
   );

   modport master (
      output TVALID, TDATA, TSTRB, TKEEP, TLAST,
      output TID, TDEST, TUSER, rd_ready,
      input  TREADY, rd_valid, rd_data, rd_strb,
      input  rd_keep, rd_last, rd_id, rd_dest, rd_user
   );
endinterface

// File: rtl/axis_rx_sink.sv
// AXI-Stream sink: FWFT FIFO buffering, protocol checks, beat/packet stats.
module axis_rx_sink #(
   parameter  int DATA_W = 32,
   parameter  int ID_W   = 4,
   parameter  int DEST_W = 4,
   parameter  int USER_W = 1,
   parameter  int DEPTH  = 8,
   localparam int KEEP_W = DATA_W / 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic          ACLK,
   input  logic          ARESET,
   axis_rx_sink_if.slave axis,
   input  logic          clr_err,
   output logic [AW:0]   level,
   output logic [31:0]   beat_cnt,
   output logic [15:0]   pkt_cnt,
   output logic          err_stable,
   output logic          err_null
);
   localparam int W = DATA_W + 2 * KEEP_W + 1 + ID_W + DEST_W + USER_W;

   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  wr_word;
   logic [W-1:0]  snap;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_next;
   logic          stall_q;
   logic          push;
   logic          pop;
   logic          tready_q;

   assign wr_word = {axis.TDATA, axis.TSTRB, axis.TKEEP, axis.TLAST,
                     axis.TID, axis.TDEST, axis.TUSER};

   assign axis.TREADY   = tready_q;
   assign axis.rd_valid = (level != '0);
   assign {axis.rd_data, axis.rd_strb, axis.rd_keep, axis.rd_last,
           axis.rd_id, axis.rd_dest, axis.rd_user} = mem[rd_ptr];

   assign push = axis.TVALID & tready_q;
   assign pop  = axis.rd_valid & axis.rd_ready;

   always_comb begin
      level_next = level;
      unique case (1'b1)
         push & ~pop: level_next = level + 1'b1;
         pop & ~push: level_next = level - 1'b1;
         default:     level_next = level;
      endcase
   end

   // Storage needs no reset; the pointers and level define what is valid.
   always_ff @(posedge ACLK) begin
      if (push)
         mem[wr_ptr] <= wr_word;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         tready_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         level    <= level_next;
         tready_q <= (level_next < (AW + 1)'(DEPTH));
      end
   end

   // Snapshot of last cycle's stall state and payload for the stability rule.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         stall_q <= 1'b0;
         snap    <= '0;
      end else begin
         stall_q <= axis.TVALID & ~tready_q;
         snap    <= wr_word;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET || clr_err) begin
         beat_cnt   <= '0;
         pkt_cnt    <= '0;
         err_stable <= 1'b0;
         err_null   <= 1'b0;
      end else begin
         beat_cnt <= beat_cnt + 32'(push);
         pkt_cnt  <= pkt_cnt + 16'(push & axis.TLAST);
         if (stall_q && (!axis.TVALID || wr_word != snap))
            err_stable <= 1'b1;
         if (push && axis.TKEEP == '0 && !axis.TLAST)
            err_null <= 1'b1;
      end
   end
endmodule

// File: tb/tb_axis_rx_sink.sv
// Directed self-checking bench for axis_rx_sink (DEPTH=8, DATA_W=32).
module tb_axis_rx_sink;
   logic        clk = 1'b0;
   logic        rst;
   logic        clr_err;
   logic [3:0]  level;
   logic [31:0] beat_cnt;
   logic [15:0] pkt_cnt;
   logic        err_stable;
   logic        err_null;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          errs;

   always #5 clk = ~clk;

   axis_rx_sink_if bus ();

   axis_rx_sink dut (
      .ACLK       (clk),
      .ARESET     (rst),
      .axis       (bus.slave),
      .clr_err    (clr_err),
      .level      (level),
      .beat_cnt   (beat_cnt),
      .pkt_cnt    (pkt_cnt),
      .err_stable (err_stable),
      .err_null   (err_null)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d,
                        input logic [3:0] keep, input logic last);
      bus.TVALID = v;
      bus.TDATA  = d;
      bus.TSTRB  = keep;
      bus.TKEEP  = keep;
      bus.TLAST  = last;
      bus.TID    = d[3:0];
      bus.TDEST  = d[7:4];
      bus.TUSER  = d[0];
   endtask

   initial begin
      rst         = 1'b1;
      clr_err     = 1'b0;
      bus.rd_ready = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 1'b0);
      repeat (2) step();
      check("rst_tready", 64'(bus.TREADY), 64'd0);
      check("rst_rvalid", 64'(bus.rd_valid), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_beats", 64'(beat_cnt), 64'd0);
      check("rst_pkts", 64'(pkt_cnt), 64'd0);
      check("rst_errs", 64'({err_stable, err_null}), 64'd0);
      rst = 1'b0;
      step();
      check("ready_rise", 64'(bus.TREADY), 64'd1);

      // Four beats streamed through with the consumer always ready.
      bus.rd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 32'(i), 4'hF, i == 4);
         step();
         check("t1_rvalid", 64'(bus.rd_valid), 64'd1);
         check("t1_data", 64'(bus.rd_data), 64'(i));
         check("t1_level", 64'(level), 64'd1);
      end
      drive(1'b0, 32'h0, 4'hF, 1'b0);
      step();
      check("t1_drain", 64'(level), 64'd0);
      check("t1_rvalid0", 64'(bus.rd_valid), 64'd0);
      check("t1_beats", 64'(beat_cnt), 64'd4);
      check("t1_pkts", 64'(pkt_cnt), 64'd1);

      // Fill to DEPTH, then a single pop reopens TREADY.
      bus.rd_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 4'hF, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 4'hF, 1'b0);
      check("full_level", 64'(level), 64'd8);
      check("full_tready", 64'(bus.TREADY), 64'd0);
      check("full_head", 64'(bus.rd_data), 64'h100);
      bus.rd_ready = 1'b1;
      step();
      check("pop_level", 64'(level), 64'd7);
      check("pop_tready", 64'(bus.TREADY), 64'd1);
      for (int i = 1; i < 8; i++) begin
         check("full_order", 64'(bus.rd_data), 64'h100 + 64'(i));
         step();
      end
      check("full_drain", 64'(level), 64'd0);

      // Counters clear, then 100 beats at full rate.
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("clr_beats", 64'(beat_cnt), 64'd0);
      check("clr_pkts", 64'(pkt_cnt), 64'd0);
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 32'h200 + 32'(i), 4'hF, i == 99);
         step();
         if (bus.TREADY !== 1'b1 || level !== 4'd1 ||
             bus.rd_data !== 32'h200 + 32'(i))
            errs++;
      end
      check("fullrate", 64'(errs), 64'd0);
      drive(1'b0, 32'h0, 4'hF, 1'b0);
      step();
      check("fr_beats", 64'(beat_cnt), 64'd100);
      check("fr_pkts", 64'(pkt_cnt), 64'd1);
      check("fr_level", 64'(level), 64'd0);

      // Stability: hold under stall is fine, change under stall flags.
      bus.rd_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h300 + 32'(i), 4'hF, 1'b0);
         step();
      end
      drive(1'b1, 32'hA5, 4'hF, 1'b0);
      step();
      step();
      check("stable_hold", 64'(err_stable), 64'd0);
      drive(1'b1, 32'h5A, 4'hF, 1'b0);
      step();
      check("stable_err", 64'(err_stable), 64'd1);
      drive(1'b0, 32'h0, 4'hF, 1'b0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("stable_clr", 64'(err_stable), 64'd0);
      step();
      check("stable_after", 64'(err_stable), 64'd0);
      check("stable_nonull", 64'(err_null), 64'd0);
      bus.rd_ready = 1'b1;
      repeat (8) step();
      bus.rd_ready = 1'b0;
      check("stable_drain", 64'(level), 64'd0);

      // Null beat flags but is still stored; TLAST-only beat is legal.
      drive(1'b1, 32'h77, 4'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 4'hF, 1'b0);
      check("null_err", 64'(err_null), 64'd1);
      check("null_rvalid", 64'(bus.rd_valid), 64'd1);
      check("null_data", 64'(bus.rd_data), 64'h77);
      check("null_keep", 64'(bus.rd_keep), 64'd0);
      clr_err = 1'b1;
      bus.rd_ready = 1'b1;
      step();
      clr_err = 1'b0;
      bus.rd_ready = 1'b0;
      check("null_clr", 64'(err_null), 64'd0);
      drive(1'b1, 32'h78, 4'h0, 1'b1);
      step();
      drive(1'b0, 32'h0, 4'hF, 1'b0);
      check("last_nonull", 64'(err_null), 64'd0);
      check("last_flag", 64'(bus.rd_last), 64'd1);
      check("last_data", 64'(bus.rd_data), 64'h78);
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;

      // Reset with beats buffered discards them.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h400 + 32'(i), 4'hF, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 4'hF, 1'b0);
      check("mid_level", 64'(level), 64'd3);
      rst = 1'b1;
      step();
      check("mid_rvalid", 64'(bus.rd_valid), 64'd0);
      check("mid_level0", 64'(level), 64'd0);
      check("mid_tready", 64'(bus.TREADY), 64'd0);
      rst = 1'b0;
      step();
      check("mid_rise", 64'(bus.TREADY), 64'd1);
      check("mid_cnt", 64'(beat_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
